// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code position decoder.
package gray_pkg;

   // Default Gray/binary word width.
   localparam int unsigned GRAY_WIDTH = 4;

   // Widest word the conversion helper handles; callers zero-extend into it.
   localparam int unsigned GRAY_MAX_WIDTH = 32;

   // Decoder tracking state: waiting for a first value, or following steps.
   typedef enum logic [0:0] {
      INIT  = 1'b0,
      TRACK = 1'b1
   } pos_state_e;

   // Gray to binary over the low 'width' bits: b[msb] = g[msb], b[i] = b[i+1] ^ g[i].
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
      input logic [GRAY_MAX_WIDTH-1:0] g,
      input int                        width
   );
      logic [GRAY_MAX_WIDTH-1:0] b;
      logic                      acc;
      b   = '0;
      acc = 1'b0;
      for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
         if (i < width) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-stage flop synchroniser for an asynchronous bus, reset to zero.
module sync_ff_chain #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   // Shift the input one stage deeper every clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         // NOTE: non-blocking so each stage takes its predecessor's pre-edge value.
         stage_q <= {stage_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_pos_decoder.sv
// Gray-coded position input: synchronise, deglitch, convert to binary and
// report accepted positions with step direction and non-adjacent-jump flag.
module gray_pos_decoder
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH         = GRAY_WIDTH,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             valid,
   output logic             dir_up,
   output logic             step_err,
   output logic             locked
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);

   logic [WIDTH-1:0] sync_code;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] cand_bin;
   logic [WIDTH-1:0] diff;
   logic             stable;

   pos_state_e       state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             valid_q, valid_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;

   sync_ff_chain #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (gray_in),
      .q_o (sync_code)
   );

   // Stability filter: the counter holds how many consecutive synchronised
   // cycles the candidate has been seen, counting the cycle it was loaded.
   // A change reloads the candidate; the candidate becomes stable on the
   // cycle the count reaches STABLE_CYCLES, and only once per run.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (sync_code != cand_q) begin
         cand_d = sync_code;
         cnt_d  = CNT_W'(1);
      end else if (cnt_q != CNT_FULL) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign stable   = (cnt_d == CNT_FULL) && (cnt_q != CNT_FULL);
   assign cand_bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(cand_d), int'(WIDTH)));
   assign diff     = cand_bin - bin_q;

   // Tracking FSM: first stable value locks, later ones are classified as
   // up, down or a non-adjacent jump (accepted anyway).
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      dir_d   = dir_q;
      case (state_q)
         INIT: begin
            if (stable) begin
               bin_d   = cand_bin;
               valid_d = 1'b1;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (stable && (cand_bin != bin_q)) begin
               bin_d   = cand_bin;
               valid_d = 1'b1;
               if (diff == WIDTH'(1)) begin
                  dir_d = 1'b1;
               end else if (diff == '1) begin
                  dir_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   // Filter, FSM and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q  <= '0;
         cnt_q   <= '0;
         state_q <= INIT;
         bin_q   <= '0;
         valid_q <= 1'b0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         bin_q   <= bin_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   assign bin_out  = bin_q;
   assign valid    = valid_q;
   assign dir_up   = dir_q;
   assign step_err = err_q;
   assign locked   = (state_q == TRACK);

endmodule
